// File: rtl/gol_pkg.sv
// Shared types and constants for the Game of Life generation engine.
package gol_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    FLUSH   = 3'd3,
    DONE    = 3'd4
  } gol_state_t;

  localparam int DEF_ROWS = 16;
  localparam int DEF_COLS = 16;

  // Width of the wrapped neighbour count and the two live thresholds.
  localparam int                CNT_W       = 2;
  localparam logic [CNT_W-1:0]  BIRTH_CNT   = 2'd3;
  localparam logic [CNT_W-1:0]  SURVIVE_CNT = 2'd2;

endpackage

// File: rtl/gol_row_next.sv
// Combinational next-generation rule for one row, given the rows above and below.
module gol_row_next
  import gol_pkg::*;
#(
  parameter int COLS = DEF_COLS
) (
  input  logic [COLS-1:0] above,
  input  logic [COLS-1:0] cur,
  input  logic [COLS-1:0] below,
  output logic [COLS-1:0] next
);

  // Neighbour count folded to 2 bits: 0..3 pass through, 4 and above read as 0
  // so that overcrowded cells can never match the birth/survive thresholds.
  function automatic logic [CNT_W-1:0] sat_cnt(input logic [7:0] nb);
    logic [3:0] sum;
    sum = 4'd0;
    for (int i = 0; i < 8; i++) begin
      sum = sum + {3'd0, nb[i]};
    end
    sat_cnt = (sum >= 4'd4) ? '0 : sum[CNT_W-1:0];
  endfunction

  // One dead column on each side keeps the edges dead without wrap-around.
  logic [COLS+1:0] above_pad;
  logic [COLS+1:0] cur_pad;
  logic [COLS+1:0] below_pad;

  assign above_pad = {1'b0, above, 1'b0};
  assign cur_pad   = {1'b0, cur,   1'b0};
  assign below_pad = {1'b0, below, 1'b0};

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [7:0]       nb;
    logic [CNT_W-1:0] cnt;

    assign nb = {above_pad[c+2], above_pad[c+1], above_pad[c],
                 cur_pad[c+2],                   cur_pad[c],
                 below_pad[c+2], below_pad[c+1], below_pad[c]};
    assign cnt     = sat_cnt(nb);
    assign next[c] = (cnt == BIRTH_CNT) | (cur[c] & (cnt == SURVIVE_CNT));
  end

endmodule

// File: rtl/gol_gen_engine.sv
// Computes one Game of Life generation in place in an external row-wide frame buffer.
module gol_gen_engine
  import gol_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [ROW_W-1:0] rd_row,
  input  logic [COLS-1:0]  rd_data,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [COLS-1:0]  wr_data,
  output logic [15:0]      gen_count,
  output logic             stable
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  gol_state_t       state;
  gol_state_t       state_nx;
  logic [ROW_W-1:0] ptr;
  logic [COLS-1:0]  prev_row;
  logic [COLS-1:0]  cur_row;
  logic [COLS-1:0]  below_row;
  logic [COLS-1:0]  next_row;
  logic             diff;

  // The row below is the word arriving from the buffer, or all dead past the last row.
  assign below_row = (state == CAPTURE) ? rd_data : '0;

  gol_row_next #(.COLS(COLS)) u_row_next (
    .above (prev_row),
    .cur   (cur_row),
    .below (below_row),
    .next  (next_row)
  );

  // Next-state and strobe decode; reads and writes fall in different states so they never overlap.
  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = 1'b0;
    rd_en    = 1'b0;
    rd_row   = '0;
    wr_en    = 1'b0;
    wr_row   = '0;
    wr_data  = '0;
    case (state)
      IDLE: begin
        if (step) state_nx = READ;
      end
      READ: begin
        rd_en    = 1'b1;
        rd_row   = ptr;
        state_nx = CAPTURE;
      end
      CAPTURE: begin
        if (ptr != '0) begin
          wr_en   = 1'b1;
          wr_row  = ptr - ROW_W'(1);
          wr_data = next_row;
        end
        state_nx = (ptr == LAST_ROW) ? FLUSH : READ;
      end
      FLUSH: begin
        wr_en    = 1'b1;
        wr_row   = LAST_ROW;
        wr_data  = next_row;
        state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register, sliding window, change tracking and generation statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      prev_row  <= '0;
      cur_row   <= '0;
      diff      <= 1'b0;
      gen_count <= '0;
      stable    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (step) begin
            ptr      <= '0;
            prev_row <= '0;
            cur_row  <= '0;
            diff     <= 1'b0;
          end
        end
        CAPTURE: begin
          if (wr_en && (next_row != cur_row)) diff <= 1'b1;
          prev_row <= cur_row;
          cur_row  <= rd_data;
          if (ptr != LAST_ROW) ptr <= ptr + ROW_W'(1);
        end
        FLUSH: begin
          if (next_row != cur_row) diff <= 1'b1;
        end
        DONE: begin
          gen_count <= gen_count + 16'd1;
          stable    <= ~diff;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gol_gen_engine.sv
// Directed bench for gol_gen_engine with a behavioural single-port frame buffer.
module tb_gol_gen_engine;

  logic             clk;
  logic             reset;
  logic             step;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [3:0]       rd_row;
  logic [15:0]      rd_data;
  logic             wr_en;
  logic [3:0]       wr_row;
  logic [15:0]      wr_data;
  logic [15:0]      gen_count;
  logic             stable;

  logic [15:0][15:0] mem;
  logic [15:0][15:0] load_val;
  logic              load_en;
  int                wr_cnt;
  int                rd_cnt;

  int n_checks;
  int n_fail;

  gol_gen_engine #(.ROWS(16), .COLS(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .step      (step),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_row    (rd_row),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .gen_count (gen_count),
    .stable    (stable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame buffer: one-cycle read latency, write on the strobe edge.
  always @(posedge clk) begin
    if (load_en) mem <= load_val;
    else if (wr_en) begin
      mem[wr_row] <= wr_data;
      wr_cnt      <= wr_cnt + 1;
    end
    if (rd_en) begin
      rd_data <= mem[rd_row];
      rd_cnt  <= rd_cnt + 1;
    end
  end

  typedef struct {
    logic [15:0][15:0] init;
    logic [15:0][15:0] expd;
    logic              exp_stable;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic load_grid(input logic [15:0][15:0] g);
    @(posedge clk);
    #1 load_val = g;
    load_en = 1'b1;
    @(posedge clk);
    #1 load_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},      {31'd0, busy},      32'd0);
    check({tag, " done"},      {31'd0, done},      32'd0);
    check({tag, " rd_en"},     {31'd0, rd_en},     32'd0);
    check({tag, " wr_en"},     {31'd0, wr_en},     32'd0);
    check({tag, " rd_row"},    {28'd0, rd_row},    32'd0);
    check({tag, " wr_row"},    {28'd0, wr_row},    32'd0);
    check({tag, " wr_data"},   {16'd0, wr_data},   32'd0);
    check({tag, " gen_count"}, {16'd0, gen_count}, 32'd0);
    check({tag, " stable"},    {31'd0, stable},    32'd0);
  endtask

  // One full generation with per-cycle protocol checks; optional stray step at t+stray_at.
  task automatic run_step(input int stray_at);
    int  done_k;
    int  done_hits;
    int  overlap;
    int  n_rd;
    int  n_wr;
    logic rd_ok;
    logic wr_ok;
    logic busy_k1;
    done_k = -1; done_hits = 0; overlap = 0; n_rd = 0; n_wr = 0;
    rd_ok = 1'b1; wr_ok = 1'b1; busy_k1 = 1'b0;
    @(posedge clk);
    #1 step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (stray_at != 0 && k == stray_at) step = 1'b1;
      if (stray_at != 0 && k == stray_at + 1) step = 1'b0;
      if (k == 1) busy_k1 = busy;
      if (rd_en && wr_en) overlap++;
      if (rd_en) begin
        if (n_rd > 15 || rd_row != 4'(n_rd)) rd_ok = 1'b0;
        n_rd++;
      end
      if (wr_en) begin
        if (n_wr > 15 || wr_row != 4'(n_wr)) wr_ok = 1'b0;
        n_wr++;
      end
      if (done) begin
        done_hits++;
        if (done_k < 0) done_k = k;
      end
      if (k == 36) check("idle after done busy", {31'd0, busy}, 32'd0);
    end
    check("busy after accept", {31'd0, busy_k1}, 32'd1);
    check("done latency", done_k, 34);
    check("done pulse count", done_hits, 1);
    check("rd/wr overlap", overlap, 0);
    check("read count", n_rd, 16);
    check("write count", n_wr, 16);
    check("rd_row order", {31'd0, rd_ok}, 32'd1);
    check("wr_row order", {31'd0, wr_ok}, 32'd1);
  endtask

  initial begin
    logic [15:0][15:0] blinker_h;
    int wr_snap;
    int rd_snap;
    int busy_seen;
    n_checks = 0; n_fail = 0;
    wr_cnt = 0; rd_cnt = 0;
    load_en = 1'b0; load_val = '0;
    mem = '0;
    rd_data = '0;

    blinker_h = '0;
    blinker_h[7] = 16'h01C0;

    // 0: horizontal blinker -> vertical
    vecs[0].init = blinker_h;
    vecs[0].expd = '0;
    vecs[0].expd[6] = 16'h0080; vecs[0].expd[7] = 16'h0080; vecs[0].expd[8] = 16'h0080;
    vecs[0].exp_stable = 1'b0;
    // 1: vertical -> horizontal again (memory continues from case 0)
    vecs[1].init = vecs[0].expd;
    vecs[1].expd = blinker_h;
    vecs[1].exp_stable = 1'b0;
    // 2: corner block is a still life
    vecs[2].init = '0;
    vecs[2].init[0] = 16'h0003; vecs[2].init[1] = 16'h0003;
    vecs[2].expd = vecs[2].init;
    vecs[2].exp_stable = 1'b1;
    // 3: overcrowded 3x3
    vecs[3].init = '0;
    vecs[3].init[5] = 16'h00E0; vecs[3].init[6] = 16'h00E0; vecs[3].init[7] = 16'h00E0;
    vecs[3].expd = '0;
    vecs[3].expd[4] = 16'h0040; vecs[3].expd[5] = 16'h00A0; vecs[3].expd[6] = 16'h0110;
    vecs[3].expd[7] = 16'h00A0; vecs[3].expd[8] = 16'h0040;
    vecs[3].exp_stable = 1'b0;
    // 4: empty grid
    vecs[4].init = '0;
    vecs[4].expd = '0;
    vecs[4].exp_stable = 1'b1;
    // 5: blinker on top edge, no wrap into row 15
    vecs[5].init = '0;
    vecs[5].init[0] = 16'h0007;
    vecs[5].expd = '0;
    vecs[5].expd[0] = 16'h0002; vecs[5].expd[1] = 16'h0002;
    vecs[5].exp_stable = 1'b0;
    // 6: vertical blinker on column 15, no wrap into column 0
    vecs[6].init = '0;
    vecs[6].init[3] = 16'h8000; vecs[6].init[4] = 16'h8000; vecs[6].init[5] = 16'h8000;
    vecs[6].expd = '0;
    vecs[6].expd[4] = 16'hC000;
    vecs[6].exp_stable = 1'b0;

    // Reset held two cycles with step asserted
    reset = 1'b1;
    step  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    #1 reset = 1'b0;
    step = 1'b0;
    @(negedge clk);
    check("step during reset ignored", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      load_grid(vecs[i].init);
      run_step((i == 0) ? 5 : 0);
      @(negedge clk);
      for (int r = 0; r < 16; r++) begin
        check($sformatf("case%0d row%0d", i, r), {16'd0, mem[r]}, {16'd0, vecs[i].expd[r]});
      end
      check($sformatf("case%0d stable", i), {31'd0, stable}, {31'd0, vecs[i].exp_stable});
      check($sformatf("case%0d gen_count", i), {16'd0, gen_count}, i + 1);
    end

    // Reset in the middle of a generation
    load_grid(blinker_h);
    @(posedge clk);
    #1 step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset");
    wr_snap = wr_cnt;
    rd_snap = rd_cnt;
    @(posedge clk);
    #1 reset = 1'b0;
    busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || rd_en || wr_en) busy_seen++;
    end
    check("no activity after reset", busy_seen, 0);
    check("no writes after reset", wr_cnt - wr_snap, 0);
    check("no reads after reset", rd_cnt - rd_snap, 0);

    // Recovery generation after reset
    load_grid(blinker_h);
    run_step(0);
    @(negedge clk);
    for (int r = 5; r < 10; r++) begin
      check($sformatf("recover row%0d", r), {16'd0, mem[r]}, {16'd0, vecs[0].expd[r]});
    end
    check("recover gen_count", {16'd0, gen_count}, 32'd1);
    check("recover stable", {31'd0, stable}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
